// File: rtl/ksa_gen.sv
// rtl/ksa_gen.sv - RC4 key-scheduling engine driving an external single-port S-memory
module ksa_gen #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      addr,
  input  logic [ADDR_W-1:0]      rddata,
  output logic [ADDR_W-1:0]      wrdata,
  output logic                   wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, INIT, RDI, CAPI, RDJ, CAPJ, WRI, WRJ} state_t;

  state_t                 state_q, state_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   do_ksa_q, do_ksa_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [KW-1:0]          k_q, k_d;
  logic [ADDR_W-1:0]      si_q, si_d;
  logic [ADDR_W-1:0]      sj_q, sj_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      wrdata_q, wrdata_d;
  logic                   wren_q, wren_d;
  logic [7:0]             key_byte;

  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KW'(b)) key_byte = key_q[8*(KEY_BYTES-b)-1 -: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    do_ksa_d = do_ksa_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          key_d    = key;
          do_ksa_d = (mode != 2'b01);
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          state_d  = (mode == 2'b10) ? RDI : INIT;
        end
      end
      INIT: begin
        i_d = i_q + ADDR_W'(1);
        if (&i_q) state_d = do_ksa_q ? RDI : IDLE;
      end
      RDI:  state_d = CAPI;
      CAPI: begin
        si_d    = rddata;
        j_d     = j_q + rddata + key_byte[ADDR_W-1:0];
        state_d = RDJ;
      end
      RDJ:  state_d = CAPJ;
      CAPJ: begin
        sj_d    = rddata;
        state_d = WRI;
      end
      WRI:  state_d = WRJ;
      WRJ: begin
        i_d     = i_q + ADDR_W'(1);
        k_d     = (k_q == KW'(KEY_BYTES-1)) ? '0 : k_q + KW'(1);
        state_d = (&i_q) ? IDLE : RDI;
      end
      default: state_d = IDLE;
    endcase

    // Memory port is registered, so it is loaded from the state being entered.
    case (state_d)
      INIT: begin
        addr_d   = i_d;
        wrdata_d = i_d;
        wren_d   = 1'b1;
      end
      RDI: addr_d = i_d;
      RDJ: addr_d = j_d;
      WRI: begin
        addr_d   = i_d;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
      end
      WRJ: begin
        addr_d   = j_d;
        wrdata_d = si_d;
        wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      do_ksa_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      do_ksa_q <= do_ksa_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign rdy    = (state_q == IDLE);
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule

// File: doc/ksa_gen.md
KSA_GEN -- requirements
Module: ksa_gen

Interface
REQ-001 Parameter KEY_BYTES, default 3; number of key bytes, legal range 1..32.
REQ-002 Parameter ADDR_W, default 8; S-memory address/data width; N = 2^ADDR_W entries; legal range 4..8.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  start request; sampled only while rdy=1.
REQ-006 Port mode  input  2  operation select: 2'b00 init+KSA, 2'b01 init only, 2'b10 KSA only, 2'b11 reserved (treated as 2'b00).
REQ-007 Port rdy  output  1  high while idle and able to accept en.
REQ-008 Port key  input  8*KEY_BYTES  key, byte 0 in bits [8*KEY_BYTES-1 -: 8] (most significant byte first).
REQ-009 Port addr  output  ADDR_W  S-memory address.
REQ-010 Port rddata  input  ADDR_W  S-memory read data, valid the cycle after addr is presented (1-cycle synchronous read).
REQ-011 Port wrdata  output  ADDR_W  S-memory write data.
REQ-012 Port wren  output  1  S-memory write enable.

Function
REQ-013 States: IDLE, INIT, RDI, CAPI, RDJ, CAPJ, WRI, WRJ; rdy=1 only in IDLE.
REQ-014 In IDLE, a rising edge with en=1 latches key and mode, clears i, j and key index k to 0, and moves to INIT (modes 00/01) or RDI (mode 10).
REQ-015 INIT: each cycle addr=i, wrdata=i, wren=1, i increments; after the write with i=N-1, i wraps to 0 and the block enters RDI (modes 00/10) or IDLE (mode 01).
REQ-016 RDI: addr=i, wren=0.
REQ-017 CAPI: register si=rddata; j <= (j + rddata + keybyte[k]) mod N, keybyte truncated to ADDR_W low bits.
REQ-018 RDJ: addr=j (new value), wren=0.
REQ-019 CAPJ: register sj=rddata.
REQ-020 WRI: addr=i, wrdata=sj, wren=1.
REQ-021 WRJ: addr=j, wrdata=si, wren=1; i increments; k increments, wrapping to 0 after KEY_BYTES-1 (counter, no divider); if i was N-1, go to IDLE, else RDI.
REQ-022 When i=j, WRI and WRJ write the same location; final content equals si (the same value), matching the RC4 swap.
REQ-023 Busy duration from the accepting edge to rdy=1: N cycles (mode 01), 6N cycles (mode 10), 7N cycles (mode 00/11); N=256 gives 256/1536/1792.
REQ-024 en while busy is ignored; key and mode changes while busy have no effect.
REQ-025 en held high at completion starts a new operation on the first IDLE edge; rdy is high for that one cycle.
REQ-026 wren=0 in IDLE, RDI, CAPI, RDJ, CAPJ; addr and wrdata hold their last values when not specified.

Reset
REQ-027 rst=1 on a rising edge forces IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=j=k=0, regardless of state.
REQ-028 Reset mid-operation aborts with no further writes from the following cycle; memory contents are left partially updated.
REQ-029 rst has priority over en on the same edge.

Verification
REQ-030 ADDR_W=8, KEY_BYTES=3, mode=01, pulse en -> rdy low for 256 cycles, then S[x]=x for all x, and exactly 256 wren cycles.
REQ-031 ADDR_W=8, KEY_BYTES=3, key=24'h00033C, mode=00 -> rdy returns after 1792 cycles, and the S contents match the RC4 KSA software model for that key.
REQ-032 ADDR_W=4, KEY_BYTES=1, key=8'hFF, mode=10 with S preloaded to identity -> rdy after 96 cycles; keybyte is used as 4'hF; S matches the model with N=16.
REQ-033 KEY_BYTES=5, key=40'h0102030405, mode=00 -> k cycles 0..4 and wraps correctly; S matches the model.
REQ-034 Assert rst in cycle 500 of a mode 00 run -> next cycle rdy=1, wren=0, addr=0; a fresh en then completes a full 1792-cycle run with the correct result.
REQ-035 Toggle en and key during a busy run -> no effect on the result; simultaneous rst=1 and en=1 in IDLE -> stays IDLE.
